mlp_layer_sequencer: RTL and testbench

Control FSM for the layered MLP datapath, the parametrised successor of the single-loop N-neuron controller.
- Sequences LAYERS layers; each layer runs INPUTS multiply-accumulate steps.
- Weight/activation memory has a one-cycle read latency, so the accumulator enable is pipelined behind the read.
- Honours a memory stall and produces clear/accumulate/write strobes, layer and input addresses, and busy/done status.

---
 rtl/mlp_layer_sequencer_pkg.sv | 25 ++
 rtl/mlp_layer_sequencer_if.sv | 52 +++++
 rtl/mlp_layer_sequencer_term_counter.sv | 35 +++
 rtl/mlp_layer_sequencer.sv | 144 ++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_seq_pkg
//  Description : Shared types and helpers for the layered MLP sequencer:
//                FSM state encoding and the address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Width of a counter able to address n items; a single item still gets one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_layer_sequencer_if
//  Description : Control bus between the layer sequencer (master) and the
//                MLP datapath / memory (slave). The abort input exists only
//                when MLP_SEQ_ABORT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mlp_layer_sequencer_if import mlp_seq_pkg::*; #(
  parameter int LAYERS = 3,
  parameter int INPUTS = 4
) ();

  localparam int LW = cw(LAYERS);
  localparam int IW = cw(INPUTS);

  logic          start;
  logic          stall;
`ifdef MLP_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          read_en;
  logic          acc_clr;
  logic          acc_en;
  logic          write_en;
  logic          busy;
  logic          done;
  logic [LW-1:0] layer_addr;
  logic [IW-1:0] in_addr;

`ifdef MLP_SEQ_ABORT_EN
  modport master (
    input  start, stall, abort,
    output read_en, acc_clr, acc_en, write_en, busy, done, layer_addr, in_addr
  );
  modport slave (
    output start, stall, abort,
    input  read_en, acc_clr, acc_en, write_en, busy, done, layer_addr, in_addr
  );
`else
  modport master (
    input  start, stall,
    output read_en, acc_clr, acc_en, write_en, busy, done, layer_addr, in_addr
  );
  modport slave (
    output start, stall,
    input  read_en, acc_clr, acc_en, write_en, busy, done, layer_addr, in_addr
  );
`endif

endinterface
`default_nettype wire

// File: rtl/mlp_layer_sequencer_term_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_term_counter
//  Description : Saturating up-counter 0..MAX-1 with synchronous clear and a
//                terminal-count flag. Never wraps: inc at the terminal value
//                is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_term_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic [W-1:0]      cnt,
  output logic              last
);

  localparam logic [W-1:0] c_term = W'(MAX - 1);

  assign last = (cnt == c_term);

  // Count up on inc until the terminal value; clear has priority over inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_layer_sequencer
//  Description : Control FSM for the layered MLP datapath. Runs LAYERS layers
//                of INPUTS multiply-accumulate steps each, pipelining the
//                accumulator enable one cycle behind the memory read and
//                honouring a memory stall.
//                Optional: define MLP_SEQ_ABORT_EN to add an abort input that
//                returns the sequencer to IDLE from any active state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer import mlp_seq_pkg::*; #(
  parameter int LAYERS = 3,
  parameter int INPUTS = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mlp_layer_sequencer_if.master   bus
);

  localparam int LW = cw(LAYERS);
  localparam int IW = cw(INPUTS);

  state_t          r_state;
  logic            r_read_en;
  logic            r_acc_clr;
  logic            r_acc_en;
  logic            r_write_en;
  logic            r_busy;
  logic            r_done;

  logic [LW-1:0]   w_layer;
  logic [IW-1:0]   w_in;
  logic            w_layer_last;
  logic            w_in_last;
  logic            w_abort;
  logic            w_accept;
  logic            w_in_clr;
  logic            w_layer_clr;
  logic            w_layer_inc;

`ifdef MLP_SEQ_ABORT_EN
  assign w_abort = bus.abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // A read is accepted when it is requested and memory is not stalling.
  assign w_accept    = r_read_en && !bus.stall;
  assign w_in_clr    = (r_state == CLR) || (r_state == DONE) || w_abort;
  assign w_layer_clr = (r_state == DONE) || w_abort;
  assign w_layer_inc = (r_state == WB);

  mlp_term_counter #(.MAX(INPUTS), .W(IW)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_in_clr),
    .inc  (w_accept),
    .cnt  (w_in),
    .last (w_in_last)
  );

  mlp_term_counter #(.MAX(LAYERS), .W(LW)) u_layer_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_layer_clr),
    .inc  (w_layer_inc),
    .cnt  (w_layer),
    .last (w_layer_last)
  );

  // Sequencer FSM; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_state    <= IDLE;
      r_read_en  <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_acc_en   <= 1'b0;
      r_write_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_read_en  <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      // Accumulate the datum whose read was accepted this cycle.
      r_acc_en   <= w_accept;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= CLR;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        CLR: begin
          r_state   <= MAC;
          r_read_en <= 1'b1;
        end
        MAC: begin
          if (!bus.stall && w_in_last) begin
            r_state <= DRAIN;
          end else begin
            r_read_en <= 1'b1;
          end
        end
        DRAIN: begin
          r_state    <= WB;
          r_write_en <= 1'b1;
        end
        WB: begin
          if (w_layer_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= CLR;
            r_acc_clr <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_en    = r_read_en;
  assign bus.acc_clr    = r_acc_clr;
  assign bus.acc_en     = r_acc_en;
  // An abort in WB/DONE must not let the write-back or completion escape.
  assign bus.write_en   = r_write_en && !w_abort;
  assign bus.done       = r_done && !w_abort;
  assign bus.busy       = r_busy;
  assign bus.layer_addr = w_layer;
  assign bus.in_addr    = w_in;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_layer_sequencer
//  Description : Self-checking bench for mlp_layer_sequencer. Two instances
//                (3x4 and 1x1) share one stimulus table of directed and
//                random start/stall/rst (and abort) patterns; a schedule-level
//                reference model predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

  localparam int N = 700;

  logic clk;
  logic rst;

  mlp_layer_sequencer_if #(.LAYERS(3), .INPUTS(4)) bus_a ();
  mlp_layer_sequencer_if #(.LAYERS(1), .INPUTS(1)) bus_b ();

  mlp_layer_sequencer #(.LAYERS(3), .INPUTS(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mlp_layer_sequencer #(.LAYERS(1), .INPUTS(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  bit          rst_pat   [N];
  bit          start_pat [N];
  bit          stall_pat [N];
  bit          abort_pat [N];
  logic [21:0] mdl       [N];
  logic [21:0] exp_a     [N];
  logic [21:0] exp_b     [N];
  logic [21:0] obs_a     [N];
  logic [21:0] obs_b     [N];

  int n_tests = 0;
  int n_fail  = 0;

  // Vector layout: {read_en, acc_clr, acc_en, write_en, busy, done, layer[7:0], in[7:0]}
  function automatic logic [21:0] pk(input bit rd, input bit clr, input bit acc, input bit wr,
                                     input bit bsy, input bit dn, input int lay, input int inx);
    return {rd, clr, acc, wr, bsy, dn, 8'(lay), 8'(inx)};
  endfunction

  // Records one expected cycle; returns 1 when the run ends after it.
  function automatic bit emit(input int t, input bit rd, input bit clr, input bit acc, input bit wr,
                              input bit bsy, input bit dn, input int lay, input int inx);
    bit ab;
    if (t >= N) return 1'b1;
    ab = bsy && abort_pat[t];
    if (ab) begin
      wr = 1'b0;
      dn = 1'b0;
    end
    mdl[t] = pk(rd, clr, acc, wr, bsy, dn, lay, inx);
    return rst_pat[t] || ab;
  endfunction

  // Walks the stimulus table run by run: per layer one clear cycle, one read
  // per input (repeated while stalled), a drain cycle and a write-back cycle,
  // then one done cycle for the whole run.
  task automatic build(input int L, input int I);
    int t;
    bit ab;
    bit pend;
    bit st;
    int inx;
    t = 1;
    while (t < N) begin
      void'(emit(t, 0, 0, 0, 0, 0, 0, 0, 0));
      if (rst_pat[t] || !start_pat[t]) begin
        t++;
        continue;
      end
      t++;
      ab   = 1'b0;
      pend = 1'b0;
      inx  = 0;
      for (int l = 0; l < L && !ab; l++) begin
        ab = emit(t, 0, 1, 0, 0, 1, 0, l, inx);
        t++;
        inx = 0;
        for (int i = 0; i < I && !ab; i++) begin
          inx = i;
          st  = 1'b1;
          while (st && !ab) begin
            st   = (t < N) ? stall_pat[t] : 1'b0;
            ab   = emit(t, 1, 0, pend, 0, 1, 0, l, inx);
            t++;
            pend = !st;
          end
        end
        if (!ab) begin
          ab = emit(t, 0, 0, pend, 0, 1, 0, l, inx);
          t++;
          pend = 1'b0;
        end
        if (!ab) begin
          ab = emit(t, 0, 0, 0, 1, 1, 0, l, inx);
          t++;
        end
      end
      if (!ab) begin
        void'(emit(t, 0, 0, 0, 0, 1, 1, L - 1, inx));
        t++;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic int first_hit(input bit use_b, input int bitpos, input int lo, input int hi);
    logic [21:0] v;
    for (int t = lo; t <= hi; t++) begin
      v = use_b ? obs_b[t] : obs_a[t];
      if (v[bitpos] === 1'b1) return t;
    end
    return -1;
  endfunction

  function automatic int count_hit(input bit use_b, input int bitpos, input int lo, input int hi);
    logic [21:0] v;
    int c;
    c = 0;
    for (int t = lo; t <= hi; t++) begin
      v = use_b ? obs_b[t] : obs_a[t];
      if (v[bitpos] === 1'b1) c++;
    end
    return c;
  endfunction

  initial begin
    logic [21:0] v;
    // Directed scenarios, then random traffic.
    rst_pat[0]    = 1'b1;
    start_pat[3]  = 1'b1;                 // nominal run
    start_pat[40] = 1'b1;                 // stalled run
    stall_pat[44] = 1'b1;
    stall_pat[45] = 1'b1;
    for (int t = 70; t <= 130; t++) start_pat[t] = 1'b1;   // start held high
    start_pat[140] = 1'b1;                // run aborted by reset
    rst_pat[150]   = 1'b1;
    start_pat[160] = 1'b1;                // fresh run after reset
`ifdef MLP_SEQ_ABORT_EN
    start_pat[200] = 1'b1;
    abort_pat[214] = 1'b1;
`endif
    for (int t = 230; t < N; t++) begin
      start_pat[t] = ($urandom_range(3) == 0);
      stall_pat[t] = ($urandom_range(2) == 0);
      rst_pat[t]   = ($urandom_range(63) == 0);
`ifdef MLP_SEQ_ABORT_EN
      abort_pat[t] = ($urandom_range(39) == 0);
`endif
    end

    build(3, 4);
    for (int t = 0; t < N; t++) exp_a[t] = mdl[t];
    build(1, 1);
    for (int t = 0; t < N; t++) exp_b[t] = mdl[t];

    for (int t = 0; t < N; t++) begin
      rst         = rst_pat[t];
      bus_a.start = start_pat[t];
      bus_b.start = start_pat[t];
      bus_a.stall = stall_pat[t];
      bus_b.stall = stall_pat[t];
`ifdef MLP_SEQ_ABORT_EN
      bus_a.abort = abort_pat[t];
      bus_b.abort = abort_pat[t];
`endif
      @(negedge clk);
      obs_a[t] = {bus_a.read_en, bus_a.acc_clr, bus_a.acc_en, bus_a.write_en, bus_a.busy,
                  bus_a.done, 8'(bus_a.layer_addr), 8'(bus_a.in_addr)};
      obs_b[t] = {bus_b.read_en, bus_b.acc_clr, bus_b.acc_en, bus_b.write_en, bus_b.busy,
                  bus_b.done, 8'(bus_b.layer_addr), 8'(bus_b.in_addr)};
      if (t >= 1) begin
        check_eq($sformatf("cyc_a@%0d", t), 32'(obs_a[t]), 32'(exp_a[t]));
        check_eq($sformatf("cyc_b@%0d", t), 32'(obs_b[t]), 32'(exp_b[t]));
      end
      @(posedge clk);
      #1;
    end

    // Reset state.
    check_eq("reset_a", 32'(obs_a[1]), 32'd0);
    check_eq("reset_b", 32'(obs_b[1]), 32'd0);
    // Nominal run: start at 3 -> done at 3 + 1 + 3*(4+3).
    check_eq("nom_done_a", first_hit(0, 16, 4, 39), 25);
    check_eq("nom_acc_a", count_hit(0, 19, 4, 25), 12);
    check_eq("nom_wr_a", count_hit(0, 18, 4, 25), 3);
    v = obs_a[11];
    check_eq("nom_clr2_a", 32'(v[20]), 32'd1);
    // 1x1 instance: CLR, MAC, DRAIN, WB, DONE.
    check_eq("nom_done_b", first_hit(1, 16, 4, 39), 8);
    check_eq("nom_rd_b", count_hit(1, 21, 4, 39), 1);
    check_eq("nom_acc_b", count_hit(1, 19, 4, 39), 1);
    check_eq("nom_wr_b", count_hit(1, 18, 4, 39), 1);
    check_eq("nom_dn_b", count_hit(1, 16, 4, 39), 1);
    // Two stall cycles at in_addr 2 delay done by two.
    v = obs_a[45];
    check_eq("stall_hold", 32'(v[7:0]), 32'd2);
    check_eq("stall_done_a", first_hit(0, 16, 41, 69), 64);
    check_eq("stall_acc_a", count_hit(0, 19, 41, 64), 12);
    // start held: no restart while busy, next CLR after the IDLE cycle.
    check_eq("held_done_a", first_hit(0, 16, 71, 100), 92);
    check_eq("held_clr_a", first_hit(0, 20, 93, 100), 94);
    // Mid-run reset.
    check_eq("rst_idle_a", 32'(obs_a[151]), 32'd0);
    check_eq("rst_nodone_a", count_hit(0, 16, 141, 159), 0);
    check_eq("rst_fresh_a", first_hit(0, 16, 161, 199), 182);
`ifdef MLP_SEQ_ABORT_EN
    v = obs_a[214];
    check_eq("abort_wr_a", 32'(v[18]), 32'd0);
    check_eq("abort_idle_a", 32'(obs_a[215]), 32'd0);
    check_eq("abort_nodone_a", count_hit(0, 16, 201, 229), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
